// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix multiply engine: FSM state encoding,
// accumulator sizing and output saturation.
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_A   = 3'd1,
        ST_STREAM_B = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Full-precision dot-product width: product width plus log2 of the term count.
    function automatic int acc_width(input int in_w, input int wt_w, input int log_n);
        return in_w + wt_w + log_n;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                    input int                 out_w,
                                                    input logic               is_signed);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        if (is_signed) begin
            hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (out_w - 1));
        end else begin
            hi = (64'sd1 <<< out_w) - 64'sd1;
            lo = 64'sd0;
        end
        if (val > hi) begin
            res = hi;
        end else if (val < lo) begin
            res = lo;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/dot_product_unit.sv
// N-lane multiply/add with a single output register; operands are sign- or
// zero-extended to the accumulator width so the sum never overflows.
module dot_product_unit #(
    parameter int N  = 4,
    parameter int IW = 4,
    parameter int WW = 8,
    parameter int AW = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed_mode,
    input  logic [N*IW-1:0] a_row,
    input  logic [N*WW-1:0] b_row,
    output logic [AW-1:0]   acc_q
);

    logic [AW-1:0] a_ext_s [N];
    logic [AW-1:0] b_ext_s [N];
    logic [AW-1:0] prod_s  [N];
    logic [AW-1:0] acc_d;

    // Extend each lane, multiply, and reduce; modular AW-bit arithmetic is exact here.
    always_comb begin
        acc_d = '0;
        for (int k = 0; k < N; k++) begin
            a_ext_s[k] = {{(AW-IW){signed_mode & a_row[k*IW + IW - 1]}}, a_row[k*IW +: IW]};
            b_ext_s[k] = {{(AW-WW){signed_mode & b_row[k*WW + WW - 1]}}, b_row[k*WW +: WW]};
            prod_s[k]  = a_ext_s[k] * b_ext_s[k];
            acc_d      = acc_d + prod_s[k];
        end
    end

    // Pipeline register for the dot product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_mult_engine.sv
// Row-at-a-time matrix multiply C = A * B with start/busy/done handshake,
// run-time M/O sizes, signed/unsigned mode and saturating output.
module matrix_mult_engine
    import mm_pkg::*;
#(
    parameter int BATCH_SIZE          = 8,
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int INPUT_FEATURES      = 4,
    parameter int LOG_INPUT_FEATURES  = 2,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int INPUT_WIDTH         = 4,
    parameter int WEIGHT_WIDTH        = 8,
    parameter int OUTPUT_WIDTH        = 16,
    parameter int READ_LATENCY        = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [LOG_BATCH_SIZE:0]                 m_cfg,
    input  logic [LOG_OUTPUT_FEATURES:0]            o_cfg,
    input  logic                                    signed_mode,
    input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]   inputData,
    input  logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0]  weightData,
    output logic [LOG_BATCH_SIZE-1:0]               inputAddr,
    output logic [LOG_OUTPUT_FEATURES-1:0]          weightAddr,
    output logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData,
    output logic [LOG_BATCH_SIZE-1:0]               outputAddr,
    output logic                                    outputWrEn,
    output logic                                    busy,
    output logic                                    done
);

    localparam int AW  = acc_width(INPUT_WIDTH, WEIGHT_WIDTH, LOG_INPUT_FEATURES);
    localparam int CW  = $clog2(OUTPUT_FEATURES + READ_LATENCY + 2);
    localparam int MW  = LOG_BATCH_SIZE + 1;
    localparam int OCW = LOG_OUTPUT_FEATURES + 1;
    localparam int LB  = LOG_BATCH_SIZE;
    localparam int LO  = LOG_OUTPUT_FEATURES;

    state_e                                          state_q, state_d;
    logic [MW-1:0]                                   row_q, row_d;
    logic [MW-1:0]                                   m_q, m_d;
    logic [OCW-1:0]                                  o_q, o_d;
    logic                                            sm_q, sm_d;
    logic [CW-1:0]                                   cnt_q, cnt_d;
    logic [INPUT_FEATURES*INPUT_WIDTH-1:0]           a_row_q, a_row_d;
    logic [LB-1:0]                                   in_addr_q, in_addr_d;
    logic [LO-1:0]                                   w_addr_q, w_addr_d;
    logic [LB-1:0]                                   out_addr_q, out_addr_d;
    logic                                            out_we_q, out_we_d;
    logic                                            busy_q, busy_d;
    logic                                            done_q, done_d;
    logic [OUTPUT_FEATURES-1:0][OUTPUT_WIDTH-1:0]    rowbuf_q, rowbuf_d;
    logic [OUTPUT_FEATURES-1:0][OUTPUT_WIDTH-1:0]    out_data_q, out_data_d;

    logic [MW-1:0]           m_clamp_s;
    logic [OCW-1:0]          o_clamp_s;
    logic [AW-1:0]           acc_s;
    logic [63:0]             acc_ext_s;
    logic [OUTPUT_WIDTH-1:0] sat_val_s;
    logic [LO-1:0]           slot_s;

    assign m_clamp_s = (m_cfg > MW'(BATCH_SIZE))       ? MW'(BATCH_SIZE)       : m_cfg;
    assign o_clamp_s = (o_cfg > OCW'(OUTPUT_FEATURES)) ? OCW'(OUTPUT_FEATURES) : o_cfg;

    dot_product_unit #(
        .N  (INPUT_FEATURES),
        .IW (INPUT_WIDTH),
        .WW (WEIGHT_WIDTH),
        .AW (AW)
    ) u_dpu (
        .clk         (clk),
        .rst         (rst),
        .signed_mode (sm_q),
        .a_row       (a_row_q),
        .b_row       (weightData),
        .acc_q       (acc_s)
    );

    // Widen the registered dot product per mode, then clamp to the output width.
    always_comb begin
        acc_ext_s = {{(64-AW){sm_q & acc_s[AW-1]}}, acc_s};
        sat_val_s = OUTPUT_WIDTH'(saturate(signed'(acc_ext_s), OUTPUT_WIDTH, sm_q));
        slot_s    = LO'(cnt_q - CW'(READ_LATENCY + 1));
    end

    // Next-state and datapath control for the row sequencer.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        m_d        = m_q;
        o_d        = o_q;
        sm_d       = sm_q;
        cnt_d      = cnt_q + CW'(1);
        a_row_d    = a_row_q;
        in_addr_d  = in_addr_q;
        w_addr_d   = w_addr_q;
        out_addr_d = out_addr_q;
        out_we_d   = 1'b0;
        out_data_d = '0;
        rowbuf_d   = rowbuf_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    m_d   = m_clamp_s;
                    o_d   = o_clamp_s;
                    sm_d  = signed_mode;
                    row_d = '0;
                    if ((m_clamp_s == '0) || (o_clamp_s == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_LOAD_A;
                        in_addr_d = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_A: begin
                rowbuf_d = '0;
                if (int'(cnt_q) == READ_LATENCY) begin
                    a_row_d  = inputData;
                    cnt_d    = '0;
                    w_addr_d = '0;
                    state_d  = ST_STREAM_B;
                end else begin
                    state_d = ST_LOAD_A;
                end
            end
            ST_STREAM_B: begin
                if (int'(cnt_q) + 1 < int'(o_q)) begin
                    w_addr_d = LO'(cnt_q + CW'(1));
                end else begin
                    w_addr_d = w_addr_q;
                end
                // Column cnt-L-1 leaves the dot-product register this cycle.
                if (int'(cnt_q) >= READ_LATENCY + 1) begin
                    rowbuf_d[slot_s] = sat_val_s;
                end else begin
                    rowbuf_d = rowbuf_q;
                end
                if (int'(cnt_q) == int'(o_q) + READ_LATENCY) begin
                    cnt_d      = '0;
                    out_we_d   = 1'b1;
                    out_addr_d = row_q[LB-1:0];
                    out_data_d = rowbuf_d;
                    state_d    = ST_WRITE;
                end else begin
                    state_d = ST_STREAM_B;
                end
            end
            ST_WRITE: begin
                cnt_d = '0;
                if (int'(row_q) + 1 < int'(m_q)) begin
                    row_d     = row_q + MW'(1);
                    in_addr_d = LB'(row_q + MW'(1));
                    state_d   = ST_LOAD_A;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_LOAD_A) || (state_d == ST_STREAM_B) || (state_d == ST_WRITE);
        done_d = (state_d == ST_DONE);
    end

    // State, configuration, buffer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            m_q        <= '0;
            o_q        <= '0;
            sm_q       <= 1'b0;
            cnt_q      <= '0;
            a_row_q    <= '0;
            in_addr_q  <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
            out_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rowbuf_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            m_q        <= m_d;
            o_q        <= o_d;
            sm_q       <= sm_d;
            cnt_q      <= cnt_d;
            a_row_q    <= a_row_d;
            in_addr_q  <= in_addr_d;
            w_addr_q   <= w_addr_d;
            out_addr_q <= out_addr_d;
            out_we_q   <= out_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rowbuf_q   <= rowbuf_d;
            out_data_q <= out_data_d;
        end
    end

    assign inputAddr  = in_addr_q;
    assign weightAddr = w_addr_q;
    assign outputAddr = out_addr_q;
    assign outputData = out_data_q;
    assign outputWrEn = out_we_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Directed bench: three engines (default, 12-bit output, read latency 3) share
// one stimulus stream and A/B memory images; each gets its own read pipeline.
module tb_matrix_mult_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] m_cfg;
    logic [3:0] o_cfg;
    logic       signed_mode;

    logic [15:0] a_mem [8];
    logic [31:0] b_mem [8];

    logic [15:0]  in_d0,  in_d12, in_d3;
    logic [31:0]  w_d0,   w_d12,  w_d3;
    logic [15:0]  a3_p [3];
    logic [31:0]  b3_p [3];
    logic [2:0]   ia0, wa0, oa0, ia12, wa12, oa12, ia3, wa3, oa3;
    logic [127:0] od0, od3;
    logic [95:0]  od12;
    logic         we0, busy0, done0, we12, busy12, done12, we3, busy3, done3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int run_id = 0;
    int t0, d0s, d12s, d3s, w0s, w12s, w3s;
    int wr0 = 0, wr12 = 0, wr3 = 0, dn0 = 0, dn12 = 0, dn3 = 0;
    int dcyc0 = 0, dcyc12 = 0, dcyc3 = 0, viol0 = 0, viol12 = 0, viol3 = 0;
    logic [127:0] cap0 [8];
    logic [127:0] cap12 [8];
    logic [127:0] cap3 [8];
    int run0 [8];

    always #5 clk = ~clk;

    matrix_mult_engine dut (
        .clk(clk), .rst(rst), .start(start), .m_cfg(m_cfg), .o_cfg(o_cfg),
        .signed_mode(signed_mode), .inputData(in_d0), .weightData(w_d0),
        .inputAddr(ia0), .weightAddr(wa0), .outputData(od0), .outputAddr(oa0),
        .outputWrEn(we0), .busy(busy0), .done(done0)
    );

    matrix_mult_engine #(.OUTPUT_WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .start(start), .m_cfg(m_cfg), .o_cfg(o_cfg),
        .signed_mode(signed_mode), .inputData(in_d12), .weightData(w_d12),
        .inputAddr(ia12), .weightAddr(wa12), .outputData(od12), .outputAddr(oa12),
        .outputWrEn(we12), .busy(busy12), .done(done12)
    );

    matrix_mult_engine #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .m_cfg(m_cfg), .o_cfg(o_cfg),
        .signed_mode(signed_mode), .inputData(in_d3), .weightData(w_d3),
        .inputAddr(ia3), .weightAddr(wa3), .outputData(od3), .outputAddr(oa3),
        .outputWrEn(we3), .busy(busy3), .done(done3)
    );

    assign in_d3 = a3_p[2];
    assign w_d3  = b3_p[2];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        in_d0   <= a_mem[ia0];
        w_d0    <= b_mem[wa0];
        in_d12  <= a_mem[ia12];
        w_d12   <= b_mem[wa12];
        a3_p[0] <= a_mem[ia3];
        a3_p[1] <= a3_p[0];
        a3_p[2] <= a3_p[1];
        b3_p[0] <= b_mem[wa3];
        b3_p[1] <= b3_p[0];
        b3_p[2] <= b3_p[1];
    end

    always @(negedge clk) begin
        if (we0) begin
            cap0[oa0] <= od0;
            run0[oa0] <= run_id;
            wr0       <= wr0 + 1;
        end else if (od0 !== 128'd0) begin
            viol0 <= viol0 + 1;
        end
        if (we12) begin
            cap12[oa12] <= 128'(od12);
            wr12        <= wr12 + 1;
        end else if (od12 !== 96'd0) begin
            viol12 <= viol12 + 1;
        end
        if (we3) begin
            cap3[oa3] <= od3;
            wr3       <= wr3 + 1;
        end else if (od3 !== 128'd0) begin
            viol3 <= viol3 + 1;
        end
        if (done0) begin
            dn0 <= dn0 + 1;
            dcyc0 <= cyc;
        end
        if (done12) begin
            dn12 <= dn12 + 1;
            dcyc12 <= cyc;
        end
        if (done3) begin
            dn3 <= dn3 + 1;
            dcyc3 <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_id(input int i, input int o, input int w);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < o) r = r | (128'(j + (i % 4)) << (j * w));
        end
        return r;
    endfunction

    function automatic int exp_cyc(input int em, input int o, input int lat);
        return (em == 0) ? 1 : em * (2 * lat + o + 3) + 1;
    endfunction

    task automatic load_identity();
        for (int i = 0; i < 8; i++) begin
            a_mem[i] = 16'h0001 << (4 * (i % 4));
            b_mem[i] = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
        end
    endtask

    task automatic start_run(input int m, input int o, input logic sm);
        tick();
        m_cfg = 4'(m);
        o_cfg = 4'(o);
        signed_mode = sm;
        start = 1'b1;
        run_id++;
        t0 = cyc;
        d0s = dn0; d12s = dn12; d3s = dn3;
        w0s = wr0; w12s = wr12; w3s = wr3;
        tick();
        start = 1'b0;
        m_cfg = 4'hF;
        o_cfg = 4'h1;
        signed_mode = ~sm;
    endtask

    task automatic wait_all(input int bound);
        int n;
        n = 0;
        while (((dn0 == d0s) || (dn12 == d12s) || (dn3 == d3s)) && (n < bound)) begin
            tick();
            n++;
        end
        chk("done_seen", 128'({dn0 != d0s, dn12 != d12s, dn3 != d3s}), 128'(3'b111));
    endtask

    task automatic check_id(input int m, input int o);
        int em;
        em = (o == 0) ? 0 : m;
        chk($sformatf("writes0_m%0d_o%0d", m, o), 128'(wr0 - w0s), 128'(em));
        chk($sformatf("writes12_m%0d_o%0d", m, o), 128'(wr12 - w12s), 128'(em));
        chk($sformatf("writes3_m%0d_o%0d", m, o), 128'(wr3 - w3s), 128'(em));
        chk($sformatf("donecyc0_m%0d_o%0d", m, o), 128'(dcyc0 - t0), 128'(exp_cyc(em, o, 1)));
        chk($sformatf("donecyc12_m%0d_o%0d", m, o), 128'(dcyc12 - t0), 128'(exp_cyc(em, o, 1)));
        chk($sformatf("donecyc3_m%0d_o%0d", m, o), 128'(dcyc3 - t0), 128'(exp_cyc(em, o, 3)));
        for (int i = 0; i < em; i++) begin
            chk($sformatf("row0_%0d", i), cap0[i], exp_id(i, o, 16));
            chk($sformatf("addr0_%0d", i), 128'(run0[i]), 128'(run_id));
            chk($sformatf("row12_%0d", i), cap12[i], exp_id(i, o, 12));
            chk($sformatf("row3_%0d", i), cap3[i], exp_id(i, o, 16));
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        m_cfg = 4'd0;
        o_cfg = 4'd0;
        signed_mode = 1'b0;
        load_identity();
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("reset_ctl0", 128'({busy0, done0, we0, ia0, wa0, oa0}), 128'd0);
        chk("reset_data0", od0, 128'd0);
        chk("reset_ctl3", 128'({busy3, done3, we3, od12}), 128'd0);
        rst = 1'b1;
        tick();

        // Full 8x8 identity-like run.
        start_run(8, 8, 1'b0);
        wait_all(400);
        check_id(8, 8);

        // Oversized config clamps to 8x8.
        start_run(15, 15, 1'b0);
        wait_all(400);
        check_id(8, 8);

        // Unsigned extremes: 4*15*255 = 15300, 12-bit output saturates.
        for (int i = 0; i < 8; i++) begin
            a_mem[i] = 16'hFFFF;
            b_mem[i] = 32'hFFFF_FFFF;
        end
        start_run(2, 8, 1'b0);
        wait_all(400);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("umax0_%0d", i), cap0[i], {8{16'h3BC4}});
            chk($sformatf("umax12_%0d", i), cap12[i], 128'({8{12'hFFF}}));
            chk($sformatf("umax3_%0d", i), cap3[i], {8{16'h3BC4}});
        end

        // Signed: -8*-128*4 = 4096, -8*127*4 = -4064.
        for (int i = 0; i < 8; i++) begin
            a_mem[i] = 16'h8888;
            b_mem[i] = (i % 2 == 0) ? 32'h8080_8080 : 32'h7F7F_7F7F;
        end
        start_run(1, 8, 1'b1);
        wait_all(400);
        chk("signed0", cap0[0], {4{16'hF020, 16'h1000}});
        chk("signed12", cap12[0], 128'({4{12'h800, 12'h7FF}}));
        chk("signed3", cap3[0], {4{16'hF020, 16'h1000}});
        chk("signed_writes0", 128'(wr0 - w0s), 128'd1);

        // Partial size: unused columns must read back as zero.
        load_identity();
        start_run(3, 5, 1'b0);
        wait_all(400);
        check_id(3, 5);
        chk("partial_no_row3", 128'(run0[3] == run_id), 128'd0);

        // Empty runs finish the cycle after start with no writes.
        start_run(0, 8, 1'b0);
        wait_all(20);
        check_id(0, 8);
        start_run(5, 0, 1'b0);
        wait_all(20);
        check_id(5, 0);

        // Start while busy and while in DONE is ignored.
        start_run(2, 8, 1'b0);
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; (n < 100) && (dn0 == d0s); n++) tick();
        chk("in_done_flag", 128'(done0), 128'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_done", 128'({busy0, done0}), 128'd0);
        tick();
        chk("idle_after_done", 128'(busy0), 128'd0);
        wait_all(400);
        check_id(2, 8);

        // Reset during the second row's STREAM_B aborts the run.
        start_run(8, 8, 1'b0);
        repeat (17) tick();
        rst = 1'b0;
        #1;
        chk("midrst_ctl0", 128'({busy0, done0, we0, ia0, wa0, oa0}), 128'd0);
        chk("midrst_data0", od0, 128'd0);
        chk("midrst_ctl3", 128'({busy3, done3, we3, ia3, wa3, oa3}), 128'd0);
        chk("midrst_writes0", 128'(wr0 - w0s), 128'd1);
        repeat (3) tick();
        rst = 1'b1;
        repeat (40) tick();
        chk("postrst_writes0", 128'(wr0 - w0s), 128'd1);
        chk("postrst_writes12", 128'(wr12 - w12s), 128'd1);
        chk("postrst_writes3", 128'(wr3 - w3s), 128'd1);
        start_run(2, 8, 1'b0);
        wait_all(400);
        check_id(2, 8);

        chk("data_zero_when_idle", 128'({viol0, viol12, viol3}), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
